// File: rtl/iob_sram_resp_pkg.sv
// Shared definitions for the iob_sram_resp IOb native-bus RAM responder:
// FSM encoding, the out-of-range read pattern and the wait-state limit.
package iob_sram_resp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [31:0] ERR_RDATA       = 32'hDEAD_BEEF;
  localparam int          WAIT_STATES_MAX = 15;
  localparam int          WAIT_CNT_W      = 4;

endpackage

// File: rtl/iob_ram_sp_be.sv
// Single-port word RAM with per-byte write enables and a registered read.
// A read (en_i with no byte enable set) loads the output register; writes
// leave it untouched so it keeps the last word read.
module iob_ram_sp_be #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
) (
  input  logic                  clk_i,
  input  logic                  en_i,
  input  logic [DATA_W/8-1:0]   we_i,
  input  logic [ADDR_W-1:0]     addr_i,
  input  logic [DATA_W-1:0]     d_i,
  output logic [DATA_W-1:0]     d_o
);

  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [DATA_W-1:0] rd_q;

  // Byte-lane writes and registered read port.
  // NOTE: the storage array has no reset; clearing a RAM would turn it into
  // a huge bank of flops. Non-blocking assignments keep read-before-write
  // ordering identical in simulation and hardware.
  always_ff @(posedge clk_i) begin
    if (en_i) begin
      for (int b = 0; b < DATA_W / 8; b++) begin
        if (we_i[b]) begin
          mem[addr_i][b*8 +: 8] <= d_i[b*8 +: 8];
        end
      end
      if (we_i == '0) begin
        rd_q <= mem[addr_i];
      end
    end
  end

  assign d_o = rd_q;

endmodule

// File: rtl/iob_sram_resp.sv
// IOb native-bus responder backed by an on-chip byte-enable RAM.
// Writes complete in the acceptance cycle; reads return after
// 1 + WAIT_STATES cycles as a single-cycle rvalid_o pulse.
// Optional feature macro: IOB_SRAM_RESP_ERR_EN (sticky out-of-range flag,
// dropped out-of-range writes, ERR_RDATA for out-of-range reads).
module iob_sram_resp
  import iob_sram_resp_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int MEM_ADDR_W  = 10,
  parameter int WAIT_STATES = 0
) (
  input  logic                  clk_i,
  input  logic                  cke_i,
  input  logic                  rst_i,
  input  logic                  avalid_i,
  input  logic [ADDR_W-1:0]     addr_i,
  input  logic [DATA_W-1:0]     wdata_i,
  input  logic [DATA_W/8-1:0]   wstrb_i,
  output logic                  ready_o,
  output logic                  rvalid_o,
  output logic [DATA_W-1:0]     rdata_o,
  output logic                  err_o
);

  localparam int                    NB      = DATA_W / 8;
  localparam logic [WAIT_CNT_W-1:0] WS_INIT = WAIT_CNT_W'(WAIT_STATES);

  if (WAIT_STATES < 0 || WAIT_STATES > WAIT_STATES_MAX) begin : g_bad_wait_states
    $error("iob_sram_resp: WAIT_STATES must be within 0..15");
  end
  if (DATA_W != 32) begin : g_bad_data_w
    $error("iob_sram_resp: DATA_W must be 32");
  end
  if (ADDR_W <= MEM_ADDR_W + 2) begin : g_bad_addr_w
    $error("iob_sram_resp: ADDR_W must exceed MEM_ADDR_W + 2");
  end

  state_t                  state_q, state_d;
  logic [WAIT_CNT_W-1:0]   cnt_q, cnt_d;
  logic                    rvalid_q, rvalid_d;
  logic [DATA_W-1:0]       rdata_q, rdata_d;
  logic                    oob_q, oob_d;
  logic                    err_q, err_d;

  logic                    req_fire;
  logic                    req_write;
  logic                    addr_oob;
  logic                    oob_eff;
  logic [MEM_ADDR_W-1:0]   word_idx;
  logic [NB-1:0]           ram_we;
  logic [DATA_W-1:0]       ram_rdata;
  logic [DATA_W-1:0]       resp_data;
  logic                    unused_bits;

  assign ready_o   = (state_q == IDLE) & ~rst_i;
  assign req_fire  = avalid_i & ready_o;
  assign req_write = |wstrb_i;
  assign word_idx  = addr_i[MEM_ADDR_W+1:2];
  assign addr_oob  = |addr_i[ADDR_W-1:MEM_ADDR_W+2];

`ifdef IOB_SRAM_RESP_ERR_EN
  assign oob_eff = addr_oob;
`else
  assign oob_eff = 1'b0;
`endif

  // Byte lanes and the word offset bits are not part of the word index.
  assign unused_bits = ^{addr_i[1:0], addr_oob};

  // Out-of-range writes are squashed when the error feature is present.
  assign ram_we = (req_fire & ~oob_eff) ? wstrb_i : '0;

  iob_ram_sp_be #(
    .DATA_W (DATA_W),
    .ADDR_W (MEM_ADDR_W)
  ) u_ram (
    .clk_i  (clk_i),
    .en_i   (cke_i & req_fire),
    .we_i   (ram_we),
    .addr_i (word_idx),
    .d_i    (wdata_i),
    .d_o    (ram_rdata)
  );

  assign resp_data = oob_q ? ERR_RDATA : ram_rdata;

  // Next-state logic for the IDLE -> (WAIT) -> RESP read sequence.
  always_comb begin
    // NOTE: every _d signal takes its held value first, so no branch can
    // leave it unassigned and infer a latch.
    state_d  = state_q;
    cnt_d    = cnt_q;
    rdata_d  = rdata_q;
    oob_d    = oob_q;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        if (req_fire && !req_write) begin
          oob_d = oob_eff;
          if (WAIT_STATES == 0) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = WS_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == WAIT_CNT_W'(1)) begin
          state_d = RESP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - WAIT_CNT_W'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
        rdata_d = resp_data;
      end
      default: state_d = IDLE;
    endcase
    if (req_fire && oob_eff) begin
      err_d = 1'b1;
    end
    rvalid_d = (state_d == RESP);
  end

  // FSM, wait counter and registered outputs; cke_i freezes all but reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      oob_q    <= 1'b0;
      err_q    <= 1'b0;
    end else if (cke_i) begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      oob_q    <= oob_d;
      err_q    <= err_d;
    end
  end

  // In RESP the word comes straight from the RAM read register; otherwise
  // the last returned word is held.
  assign rvalid_o = rvalid_q;
  assign rdata_o  = rvalid_q ? resp_data : rdata_q;
  assign err_o    = err_q;

endmodule
